serial_adder_ctrl: RTL and testbench
====================================

# serial_adder_ctrl

Bit-serial multi-bit adder controller. It sequences a single one-bit full adder over `nbits` cycles to add two `nbits`-wide operands plus carry-in, LSB first, with a carry register closing the loop. Requests arrive and responses leave over val/rdy handshakes. It sits between a requester and the one-bit full-adder datapath, trading latency for area wherever a full-width adder is too costly.

## Interface
- `nbits`, default 8: operand/sum width; legal range ≥ 1.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_val`  in  1  request valid.
- `req_rdy`  out  1  controller can accept a request.
- `req_a`  in  nbits  operand A.
- `req_b`  in  nbits  operand B.
- `req_cin`  in  1  carry-in.
- `resp_val`  out  1  result valid.
- `resp_rdy`  in  1  consumer accepts result.
- `resp_sum`  out  nbits  sum, (a + b + cin) mod 2^nbits.
- `resp_cout`  out  1  carry out of bit `nbits-1`.

## Operation
- Internal state: FSM, A and B shift registers (nbits each), sum shift register (nbits), carry register (1), bit counter (width clog2(nbits)+1).
- Exactly one one-bit full-adder instance. Its inputs are A[0], B[0] and the carry register. Its outputs are the sum bit and the carry-out. No other adder logic is permitted.
- FSM states:
  - IDLE: `req_rdy`=1. On `req_val && req_rdy`, load A←`req_a`, B←`req_b`, carry←`req_cin`, counter←0, sum←0, then go to CALC.
  - CALC: each cycle the FA consumes A[0]/B[0]/carry.
    - A and B shift right by 1.
    - The sum register shifts right with the FA sum bit entering at the MSB.
    - carry←FA cout; counter increments.
    - When the counter equals nbits-1 at the edge, go to DONE.
  - DONE: `resp_val`=1. `resp_sum` = sum register and `resp_cout` = carry register, both held stable. On `resp_rdy`, go to IDLE.
- `req_rdy`=1 only in IDLE. `resp_val`=1 only in DONE. Both are combinational from state.
- Inputs `req_a`, `req_b` and `req_cin` are sampled only on the accepting edge. Changes afterwards have no effect.
- `req_val` outside IDLE is ignored. It is not queued.
- After the last CALC edge, the sum register holds bit 0 at LSB.

## Timing
- Reset: FSM←IDLE, all data registers←0, counter←0. While `reset`=1, `req_rdy`=0 and `resp_val`=0. The first cycle after reset deasserts, `req_rdy`=1, `resp_val`=0, `resp_sum`=0 and `resp_cout`=0.
- Handshake at edge ending cycle t: CALC occupies cycles t+1 … t+nbits; DONE starts at cycle t+nbits+1.
- Latency from accepting cycle to first `resp_val` cycle: nbits+1.
- With `resp_rdy` held high, the controller is back in IDLE at cycle t+nbits+2. Initiation interval is nbits+2. There is no same-cycle accept in DONE; the DONE-to-IDLE bubble is required.
- Backpressure: DONE persists indefinitely while `resp_rdy`=0. Outputs must not change.
- `resp_rdy` outside DONE has no effect.
- Reset at any state, including mid-CALC or DONE, abandons the operation at that edge. The next cycle behaves as post-reset: no response is emitted for the abandoned request.
- `nbits`=1: a single CALC cycle; latency 2.
- Wrap-around: the sum is mod 2^nbits, and overflow appears only on `resp_cout`.

## Test plan
- nbits=8; a=0x05, b=0x03, cin=0, accepted at cycle t → `resp_val` first high at t+9; sum=0x08, cout=0; `req_rdy` low during t+1…t+9.
- nbits=8; a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then a=0xFF, b=0x00, cin=1 → sum=0x00, cout=1. Then a=0x00, b=0x00, cin=1 → sum=0x01, cout=0.
- Backpressure: a=0xA5, b=0x5A, cin=1 with `resp_rdy`=0 for 5 DONE cycles → sum=0x00, cout=1 held stable all 5 cycles; `req_val`=1 with new operands during this time is ignored; after `resp_rdy`=1, IDLE the next cycle and the new request is accepted.
- Reset mid-op: assert `reset` for 1 cycle at the 3rd CALC cycle → next cycle `req_rdy`=1, `resp_val`=0, `resp_sum`=0; no stale response ever appears; a fresh 0x10+0x20 then returns 0x30.
- Back-to-back random: 1000 random (a, b, cin) with random `req_val`/`resp_rdy` stalls → every response equals a+b+cin split into {cout, sum}, in order, with exactly one response per accepted request.
- Parameter sweep: nbits=1 (all 8 input combos, latency 2) and nbits=32 (0xFFFFFFFF+0x00000001 → 0x00000000, cout=1, latency 33).

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one 1-bit full adder is stepped LSB-first over
// nbits cycles, with a carry register closing the loop and val/rdy on both sides.

module serial_full_adder (
   input  logic i_a,
   input  logic i_b,
   input  logic i_c,
   output logic o_s,
   output logic o_c
);
   assign o_s = i_a ^ i_b ^ i_c;
   assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module serial_adder_ctrl #(
   parameter int nbits = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_val,
   output logic             req_rdy,
   input  logic [nbits-1:0] req_a,
   input  logic [nbits-1:0] req_b,
   input  logic             req_cin,
   output logic             resp_val,
   input  logic             resp_rdy,
   output logic [nbits-1:0] resp_sum,
   output logic             resp_cout
);
   localparam int CW = $clog2(nbits) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(nbits - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [nbits-1:0] r_a;
   logic [nbits-1:0] r_b;
   logic [nbits-1:0] r_sum;
   logic             r_carry;
   logic [CW-1:0]    r_cnt;

   logic             w_fa_s;
   logic             w_fa_c;
   logic             w_last;
   logic [nbits-1:0] w_sum_msb;

   serial_full_adder u_fa (
      .i_a (r_a[0]),
      .i_b (r_b[0]),
      .i_c (r_carry),
      .o_s (w_fa_s),
      .o_c (w_fa_c)
   );

   assign w_last    = (r_cnt == CNT_LAST);
   // Sum bit enters at the MSB so that after nbits shifts bit 0 sits at the LSB.
   assign w_sum_msb = nbits'(w_fa_s) << (nbits - 1);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (req_val) w_state_nxt = ST_CALC;
            else         w_state_nxt = ST_IDLE;
         end
         ST_CALC: begin
            if (w_last) w_state_nxt = ST_DONE;
            else        w_state_nxt = ST_CALC;
         end
         ST_DONE: begin
            if (resp_rdy) w_state_nxt = ST_IDLE;
            else          w_state_nxt = ST_DONE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (req_val) begin
                  r_a     <= req_a;
                  r_b     <= req_b;
                  r_carry <= req_cin;
                  r_sum   <= '0;
                  r_cnt   <= '0;
               end
            end
            ST_CALC: begin
               r_a     <= r_a >> 1'b1;
               r_b     <= r_b >> 1'b1;
               r_sum   <= (r_sum >> 1'b1) | w_sum_msb;
               r_carry <= w_fa_c;
               r_cnt   <= r_cnt + CNT_ONE;
            end
            default: begin
               r_a     <= r_a;
               r_b     <= r_b;
               r_sum   <= r_sum;
               r_carry <= r_carry;
               r_cnt   <= r_cnt;
            end
         endcase
      end
   end

   // Handshake flags are masked during reset so nothing is offered or accepted.
   assign req_rdy   = (r_state == ST_IDLE) && !reset;
   assign resp_val  = (r_state == ST_DONE) && !reset;
   assign resp_sum  = r_sum;
   assign resp_cout = r_carry;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl at nbits = 8, 1 and 32; one shared
// stimulus/monitor path is steered to the selected instance.

module tb_serial_adder_ctrl;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        s_val;
   logic        s_rdy;
   logic [31:0] s_a;
   logic [31:0] s_b;
   logic        s_cin;
   int          sel;
   int          nb;
   bit          rand_rdy = 1'b0;

   logic        rdy8, val8, cout8;
   logic [7:0]  sum8;
   logic        rdy1, val1, cout1;
   logic [0:0]  sum1;
   logic        rdy32, val32, cout32;
   logic [31:0] sum32;

   logic        m_rdy, m_val, m_cout;
   logic [31:0] m_sum;

   logic [32:0] q[$];
   int          n_vec = 0;
   int          n_err = 0;

   serial_adder_ctrl #(.nbits(8)) dut8 (
      .clk(clk), .reset(reset),
      .req_val(s_val && (sel == 0)), .req_rdy(rdy8),
      .req_a(s_a[7:0]), .req_b(s_b[7:0]), .req_cin(s_cin),
      .resp_val(val8), .resp_rdy(s_rdy && (sel == 0)),
      .resp_sum(sum8), .resp_cout(cout8)
   );

   serial_adder_ctrl #(.nbits(1)) dut1 (
      .clk(clk), .reset(reset),
      .req_val(s_val && (sel == 1)), .req_rdy(rdy1),
      .req_a(s_a[0:0]), .req_b(s_b[0:0]), .req_cin(s_cin),
      .resp_val(val1), .resp_rdy(s_rdy && (sel == 1)),
      .resp_sum(sum1), .resp_cout(cout1)
   );

   serial_adder_ctrl #(.nbits(32)) dut32 (
      .clk(clk), .reset(reset),
      .req_val(s_val && (sel == 2)), .req_rdy(rdy32),
      .req_a(s_a), .req_b(s_b), .req_cin(s_cin),
      .resp_val(val32), .resp_rdy(s_rdy && (sel == 2)),
      .resp_sum(sum32), .resp_cout(cout32)
   );

   assign m_rdy  = (sel == 0) ? rdy8  : (sel == 1) ? rdy1  : rdy32;
   assign m_val  = (sel == 0) ? val8  : (sel == 1) ? val1  : val32;
   assign m_cout = (sel == 0) ? cout8 : (sel == 1) ? cout1 : cout32;
   assign m_sum  = (sel == 0) ? {24'h0, sum8} : (sel == 1) ? {31'h0, sum1} : sum32;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [32:0] model(input int n, input logic [31:0] a,
                                         input logic [31:0] b, input logic c);
      logic [31:0] m;
      logic [32:0] r;
      m = (n == 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
      r = {1'b0, a & m} + {1'b0, b & m} + {32'h0, c};
      return {r[n], r[31:0] & m};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Hold a request until accepted; the expected response is queued at acceptance.
   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic c);
      int guard = 0;
      s_a = a; s_b = b; s_cin = c; s_val = 1'b1;
      forever begin
         @(negedge clk);
         if (m_rdy) break;
         guard++;
         if (guard > 200) break;
         step();
      end
      if (m_rdy) q.push_back(model(nb, a, b, c));
      else       chk("accept_timeout", 64'd0, 64'd1);
      step();
      s_val = 1'b0;
   endtask

   // Called in cycle t+1 after an accept; measures latency to resp_val.
   task automatic wait_resp();
      int cyc = 1;
      bit rdy_seen = 1'b0;
      forever begin
         @(negedge clk);
         if (m_val || cyc > 100) break;
         if (m_rdy) rdy_seen = 1'b1;
         step();
         cyc++;
      end
      chk("latency", cyc, nb + 1);
      chk("req_rdy_low_while_busy", {rdy_seen, m_rdy}, 2'b00);
      if (s_rdy) begin
         step();
         @(negedge clk);
         chk("idle_after_done", {m_rdy, m_val}, 2'b10);
      end
      step();
   endtask

   // Monitor: pops the scoreboard whenever a response handshake is presented.
   always @(negedge clk) begin
      if (m_val && s_rdy) begin
         if (q.size() == 0) chk("unexpected_resp", {m_cout, m_sum}, 33'h0_DEAD_BEEF);
         else chk("resp", {m_cout, m_sum}, q.pop_front());
      end
   end

   initial forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) s_rdy = 1'($urandom_range(0, 1));
   end

   initial begin
      bit stale;
      reset = 1'b1; s_val = 1'b0; s_rdy = 1'b1;
      s_a = '0; s_b = '0; s_cin = 1'b0;
      sel = 0; nb = 8;
      repeat (3) step();
      @(negedge clk);
      chk("in_reset_flags", {m_rdy, m_val}, 2'b00);
      step();
      reset = 1'b0;
      @(negedge clk);
      chk("post_reset_flags", {m_rdy, m_val}, 2'b10);
      chk("post_reset_out", {m_cout, m_sum}, 33'h0);
      step();

      send(32'h05, 32'h03, 1'b0); wait_resp();
      send(32'hFF, 32'h01, 1'b0); wait_resp();
      send(32'hFF, 32'h00, 1'b1); wait_resp();
      send(32'h00, 32'h00, 1'b1); wait_resp();

      s_rdy = 1'b0;
      send(32'hA5, 32'h5A, 1'b1);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (m_val) break;
         step();
      end
      chk("bp_resp_seen", m_val, 1'b1);
      for (int i = 0; i < 5; i++) begin
         chk("bp_hold", {m_val, m_rdy, m_cout, m_sum}, {2'b10, 33'h1_0000_0000});
         step();
         if (i == 0) begin
            s_val = 1'b1; s_a = 32'h11; s_b = 32'h22; s_cin = 1'b0;
         end
         @(negedge clk);
      end
      chk("bp_still_done", {m_val, m_rdy}, 2'b10);
      step();
      s_rdy = 1'b1;
      @(negedge clk);
      step();
      @(negedge clk);
      chk("bp_idle_next", {m_rdy, m_val}, 2'b10);
      if (m_rdy) q.push_back(model(8, 32'h11, 32'h22, 1'b0));
      step();
      s_val = 1'b0;
      wait_resp();

      send(32'hAB, 32'hCD, 1'b0);
      step(); step();
      reset = 1'b1;
      @(negedge clk);
      chk("midop_reset_flags", {m_rdy, m_val}, 2'b00);
      void'(q.pop_back());
      step();
      reset = 1'b0;
      @(negedge clk);
      chk("after_abort_flags", {m_rdy, m_val}, 2'b10);
      chk("after_abort_sum", m_sum, 32'h0);
      stale = 1'b0;
      for (int i = 0; i < 15; i++) begin
         step();
         @(negedge clk);
         if (m_val) stale = 1'b1;
      end
      chk("no_stale_resp", stale, 1'b0);
      step();
      send(32'h10, 32'h20, 1'b0); wait_resp();

      rand_rdy = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         repeat ($urandom_range(0, 2)) step();
         send($urandom, $urandom, 1'($urandom_range(0, 1)));
      end
      for (int i = 0; i < 300 && q.size() != 0; i++) step();
      rand_rdy = 1'b0;
      step();
      s_rdy = 1'b1;
      chk("random_drained", q.size(), 0);
      step();

      sel = 1; nb = 1;
      step();
      for (int c = 0; c < 8; c++) begin
         send({31'h0, c[2]}, {31'h0, c[1]}, c[0]);
         wait_resp();
      end

      sel = 2; nb = 32;
      step();
      send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0); wait_resp();
      send(32'h8000_0000, 32'h7FFF_FFFF, 1'b0); wait_resp();

      repeat (3) step();
      chk("queue_empty", q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
